// File: rtl/ethernet_tx_if.sv
// rtl/ethernet_tx_if.sv - payload byte stream into the RMII Ethernet transmitter
interface ethernet_tx_if;
  logic [7:0] axiid;
  logic       axiiv;
  logic       axiil;
  logic       axiir;

  modport master (output axiid, output axiiv, output axiil, input axiir);
  modport slave  (input axiid, input axiiv, input axiil, output axiir);
endinterface

// File: rtl/ethernet_tx.sv
// rtl/ethernet_tx.sv - RMII Ethernet MAC transmitter (preamble, header, payload, pad, FCS, IFG)
// Optional FCS generation is enabled by defining ETH_TX_FCS_EN.
module ethernet_tx #(
  parameter int N = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [47:0]   mac,
  input  logic [47:0]   dst_mac,
  input  logic [15:0]   ethertype,
  input  logic          tx_start,
  ethernet_tx_if.slave  pay,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          tx_err,
  output logic          eth_txen,
  output logic [N-1:0]  eth_txd
);

  if (N != 2) begin : g_bad_width
    $error("ethernet_tx supports only N == 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_PAD, S_FCS, S_IFG} state_t;

`ifdef ETH_TX_FCS_EN
  localparam state_t S_END = S_FCS;
`else
  localparam state_t S_END = S_IFG;
`endif

  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [111:0]  hdr_q;
  logic [7:0]    byte_q, byte_d;
  logic          last_q, last_d;
  logic [10:0]   bcnt_q, bcnt_d;
  logic          accept, abort, pad_more;
  logic          axiir_q;
  logic          txen_d, busy_d, done_d, err_d, rdy_d;
  logic [N-1:0]  txd_d;
  logic [6:0]    hpos;

  assign pad_more = (bcnt_q < 11'd46);
  assign pay.axiir = axiir_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      if (state_q == S_IDLE && tx_start) hdr_q <= {dst_mac, mac, ethertype};
    end
  end

  // cnt counts dibits within the current phase; in PAY/PAD it wraps every byte.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 6'd1;
    accept  = 1'b0;
    abort   = 1'b0;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    byte_d  = byte_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_start) begin
          state_d = S_PRE;
          last_d  = 1'b0;
          bcnt_d  = '0;
        end
      end
      S_PRE: if (cnt_q == 6'd31) begin
        state_d = S_HDR;
        cnt_d   = '0;
      end
      S_HDR, S_PAY: begin
        if (axiir_q) begin
          cnt_d = '0;
          if (pay.axiiv) begin
            accept  = 1'b1;
            state_d = S_PAY;
          end else begin
            abort   = 1'b1;
            state_d = S_IFG;
          end
        end else if (state_q == S_PAY && cnt_q[1:0] == 2'd3) begin
          cnt_d   = '0;
          state_d = pad_more ? S_PAD : S_END;
        end
      end
      S_PAD: if (cnt_q[1:0] == 2'd3) begin
        cnt_d   = '0;
        state_d = pad_more ? S_PAD : S_END;
      end
      S_FCS: if (cnt_q == 6'd15) begin
        state_d = S_IFG;
        cnt_d   = '0;
      end
      S_IFG: if (cnt_q == 6'd47) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      byte_d = pay.axiid;
      last_d = pay.axiil;
    end
    if (state_d == S_PAD && cnt_d == 6'd0) byte_d = '0;
    if ((state_d == S_PAY || state_d == S_PAD) && cnt_d == 6'd0 && bcnt_q != 11'd2047)
      bcnt_d = bcnt_q + 11'd1;
  end

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++)
      r = {1'b0, r[31:1]} ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (state_q == S_IDLE)
      crc_d = 32'hFFFFFFFF;
    else if (state_d == S_HDR || state_d == S_PAY || state_d == S_PAD)
      crc_d = crc_step(crc_q, txd_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_q <= 32'hFFFFFFFF;
    else      crc_q <= crc_d;
  end
`endif

  // Header bytes go out MSB byte first, each byte LSB dibit first.
  assign hpos = 7'd104 - {cnt_d[5:2], 3'b000} + {4'b0000, cnt_d[1:0], 1'b0};

  always_comb begin
    txen_d = (state_d == S_PRE) || (state_d == S_HDR) || (state_d == S_PAY) ||
             (state_d == S_PAD) || (state_d == S_FCS);
    busy_d = (state_d != S_IDLE);
    err_d  = abort;
    txd_d  = '0;
    rdy_d  = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_PRE: txd_d = (cnt_d == 6'd31) ? 2'b11 : 2'b01;
      S_HDR: begin
        txd_d = hdr_q[hpos +: 2];
        rdy_d = (cnt_d == 6'd55);
      end
      S_PAY: begin
        txd_d = byte_d[{cnt_d[1:0], 1'b0} +: 2];
        rdy_d = (cnt_d[1:0] == 2'd3) && !last_d;
`ifndef ETH_TX_FCS_EN
        done_d = (cnt_d[1:0] == 2'd3) && last_d && (bcnt_d >= 11'd46);
`endif
      end
      S_PAD: begin
`ifndef ETH_TX_FCS_EN
        done_d = (cnt_d[1:0] == 2'd3) && (bcnt_d >= 11'd46);
`endif
      end
`ifdef ETH_TX_FCS_EN
      S_FCS: begin
        txd_d  = ~crc_q[{cnt_d[3:0], 1'b0} +: 2];
        done_d = (cnt_d == 6'd15);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eth_txen <= 1'b0;
      eth_txd  <= '0;
      axiir_q  <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      eth_txen <= txen_d;
      eth_txd  <= txd_d;
      axiir_q  <= rdy_d;
      tx_busy  <= busy_d;
      tx_done  <= done_d;
      tx_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_ethernet_tx.sv
// tb/tb_ethernet_tx.sv - randomized self-checking bench for ethernet_tx against a byte-level frame model
module tb_ethernet_tx;

`ifdef ETH_TX_FCS_EN
  localparam int FCS_CYC = 16;
`else
  localparam int FCS_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [47:0] mac = '0;
  logic [47:0] dst = '0;
  logic [15:0] et = '0;
  logic        tx_start = 1'b0;
  logic        tx_busy, tx_done, tx_err, eth_txen;
  logic [1:0]  eth_txd;

  ethernet_tx_if pay_if ();

  ethernet_tx #(.N(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mac       (mac),
    .dst_mac   (dst),
    .ethertype (et),
    .tx_start  (tx_start),
    .pay       (pay_if),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err),
    .eth_txen  (eth_txen),
    .eth_txd   (eth_txd)
  );

  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int n_printed = 0;

  // Per-cycle record: {txen, txd[1:0], busy, done, err, axiir}
  logic [6:0] exp_q[$];
  logic [7:0] pay[$];
  logic [7:0] crcq[$];
  int plen = 0;
  int under_i = -1;
  bit checking = 0;
  int cyc_i, txen_cnt, rdy_cnt, err_cnt, done_cyc;

  task automatic chk(input string name, input longint got, input longint want);
    n_assert++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_byte(input logic [7:0] b, input bit rdy);
    for (int j = 0; j < 4; j++)
      exp_q.push_back({1'b1, b[2*j +: 2], 1'b1, 1'b0, 1'b0, rdy && (j == 3)});
  endtask

  task automatic build();
    logic [111:0] h;
    logic [7:0]   b;
    logic [31:0]  f;
    logic [6:0]   t;
    int           nsent;
    exp_q.delete();
    crcq.delete();
    for (int i = 0; i < 7; i++) push_byte(8'h55, 1'b0);
    push_byte(8'hD5, 1'b0);
    h = {dst, mac, et};
    for (int i = 0; i < 14; i++) begin
      b = h[111 - 8*i -: 8];
      push_byte(b, i == 13);
      crcq.push_back(b);
    end
    nsent = (under_i >= 0) ? under_i : plen;
    for (int k = 0; k < nsent; k++) begin
      push_byte(pay[k], k < plen - 1);
      crcq.push_back(pay[k]);
    end
    if (under_i >= 0) begin
      exp_q.push_back(7'b0001010);
      repeat (47) exp_q.push_back(7'b0001000);
    end else begin
      for (int p = plen; p < 46; p++) begin
        push_byte(8'h00, 1'b0);
        crcq.push_back(8'h00);
      end
`ifdef ETH_TX_FCS_EN
      f = fcs_of(crcq);
      for (int i = 0; i < 4; i++) push_byte(f[8*i +: 8], 1'b0);
`else
      f = '0;
`endif
      t = exp_q.pop_back();
      t[2] = 1'b1;
      exp_q.push_back(t);
      repeat (48) exp_q.push_back(7'b0001000);
    end
    exp_q.push_back(7'b0000000);
  endtask

  task automatic drive_pay(input int k);
    if (k < plen) begin
      pay_if.axiid = pay[k];
      pay_if.axiiv = (k != under_i);
      pay_if.axiil = (k == plen - 1);
    end else begin
      pay_if.axiid = 8'h00;
      pay_if.axiiv = 1'b0;
      pay_if.axiil = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    logic [6:0] got, want;
    if (checking && exp_q.size() > 0) begin
      got  = {eth_txen, eth_txd, tx_busy, tx_done, tx_err, pay_if.axiir};
      want = exp_q.pop_front();
      cyc_i++;
      n_assert++;
      if (got !== want) begin
        n_fail++;
        if (n_printed < 30)
          $display("FAIL cycle_check cyc=%0d got=%b want=%b", cyc_i, got, want);
        n_printed++;
      end
      txen_cnt += int'(eth_txen);
      rdy_cnt  += int'(pay_if.axiir);
      err_cnt  += int'(tx_err);
      if (tx_done) done_cyc = cyc_i;
      if (exp_q.size() == 0) checking = 0;
    end
  end

  task automatic run_frame(input bit poke);
    int  k, t;
    bit  acc;
    build();
    k = 0;
    drive_pay(0);
    cyc_i = 0; txen_cnt = 0; rdy_cnt = 0; err_cnt = 0; done_cyc = -1;
    @(posedge clk); #1 tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    checking = 1;
    t = 0;
    while (checking && t < 3000) begin
      @(negedge clk);
      acc = pay_if.axiir && pay_if.axiiv;
      @(posedge clk); #1;
      if (acc) k++;
      drive_pay(k);
      tx_start = poke && (t == 100);
      t++;
    end
    tx_start = 1'b0;
    if (checking) begin
      checking = 0;
      n_assert++;
      n_fail++;
      $display("FAIL frame_timeout got=%0d want=0 pending", exp_q.size());
    end
  endtask

  task automatic rand_hdr();
    mac = {$urandom, $urandom};
    dst = {$urandom, $urandom};
    et  = 16'($urandom);
  endtask

  task automatic fill_pay(input int n, input bit seq);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(seq ? 8'(i) : 8'($urandom));
    plen = n;
  endtask

  initial begin
    logic [7:0] chkstr[$];
    pay_if.axiid = 8'h00;
    pay_if.axiiv = 1'b0;
    pay_if.axiil = 1'b0;

    // reset defaults
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_outputs", {eth_txen, eth_txd, tx_busy, tx_done, tx_err, pay_if.axiir}, 0);

    // model pins
    chkstr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_model_check", fcs_of(chkstr), 32'hCBF43926);

    // minimal frame
    dst = 48'hFFFFFFFFFFFF; mac = 48'h020000000001; et = 16'h0806;
    pay.delete(); pay.push_back(8'hAB); plen = 1; under_i = -1;
    build();
    chk("model_min_len", exp_q.size(), 288 - 16 + FCS_CYC + 48 + 1);
    chk("model_sfd_dibit", exp_q[31][5:4], 2'b11);
    chk("model_first_hdr_dibit", exp_q[32][5:4], 2'b11);
    run_frame(1'b0);
    chk("min_txen_len", txen_cnt, 272 + FCS_CYC);
    chk("min_done_cycle", done_cyc, 272 + FCS_CYC);
    chk("min_axiir_count", rdy_cnt, 1);

    // long frame with an ignored tx_start during payload
    rand_hdr(); fill_pay(100, 1'b1); under_i = -1;
    run_frame(1'b1);
    chk("long_txen_len", txen_cnt, 488 + FCS_CYC);
    chk("long_axiir_count", rdy_cnt, 100);
    chk("long_done_cycle", done_cyc, 488 + FCS_CYC);

    // underrun at byte 10
    rand_hdr(); fill_pay(20, 1'b0); under_i = 10;
    run_frame(1'b0);
    chk("under_err_count", err_cnt, 1);
    chk("under_txen_len", txen_cnt, 32 + 56 + 40);
    chk("under_no_done", done_cyc, -1);

    // reset during header
    rand_hdr(); plen = 0; under_i = -1; drive_pay(0);
    @(posedge clk); #1 tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    repeat (40) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("reset_mid_txen", eth_txen, 0);
    chk("reset_mid_busy", tx_busy, 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    rand_hdr(); fill_pay(5, 1'b0); under_i = -1;
    run_frame(1'b0);
    chk("post_reset_txen_len", txen_cnt, 272 + FCS_CYC);

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      rand_hdr();
      fill_pay(int'($urandom_range(1, 70)), 1'b0);
      under_i = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, plen - 1)) : -1;
      run_frame(f[0]);
      chk("rand_err_count", err_cnt, (under_i >= 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
